lsu: RTL
========

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the RISC-V core.
- Takes alu_res as the effective address and rs2 as store data.
- Runs one data-memory transaction over a req/gnt/rvalid handshake and returns sign/zero-extended load data to writeback.
- Stalls the core via lsu_busy while a transaction is in flight.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- TIMEOUT, 16, watchdog limit in cycles. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- lsu_valid  in  1  execute stage presents a memory instruction
- lsu_op  in  op_enum_lsu  LSU_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
- lsu_addr  in  XLEN  effective address (alu_res)
- lsu_wdata  in  XLEN  store data (rs2)
- lsu_busy  out  1  stall request to core
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  XLEN  extended load result
- lsu_misalign  out  1  valid with lsu_done: access was misaligned and not performed
- lsu_fault  out  1  valid with lsu_done: watchdog abort (tied 0 without LSU_TIMEOUT_EN)
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state goes to IDLE. All registered outputs clear to 0. lsu_busy is forced to 0 while rst_n=0. Reset mid-transaction abandons it; a late mem_rvalid afterwards is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, lsu_valid=1 and lsu_op!=LSU_NONE: lsu_busy=1 combinationally.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to DONE with misalign flag set. No memory access is made.
  - Otherwise: latch mem_addr, mem_we, mem_be, mem_wdata, op and addr[1:0], then go to REQ.
- REQ: mem_req=1, lsu_busy=1. Address, we, be and wdata stay stable until mem_gnt.
  - On mem_gnt, a store goes to DONE; a load goes to WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT: lsu_busy=1. On mem_rvalid, register the extended data into lsu_rdata and go to DONE.
- DONE: lsu_done=1, lsu_busy=0, go to IDLE. The core retires the instruction this cycle. A request cannot be accepted in DONE.
- Minimum latency (acceptance to lsu_done):
  - store: 2 cycles (gnt in the first REQ cycle)
  - load: 3 cycles (rvalid the cycle after gnt)
  - misaligned: 1 cycle
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{d[15:0]}}
  - SW: be=4'b1111, wdata=d
- Load extraction uses the latched addr[1:0]:
  - LB/LBU: byte lane addr[1:0], sign/zero-extended
  - LH/LHU: halfword lane addr[1], sign/zero-extended
  - LW: full word
  - Loads drive mem_be=4'b1111.
- lsu_rdata holds its value except when a load completes. Stores, misaligned and faulted accesses leave it unchanged.
- lsu_misalign and lsu_fault are 0 whenever lsu_done=0.
- mem_* registers outside REQ hold their last values; they are only meaningful while mem_req=1.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ or WAIT and increments each cycle spent there. On reaching TIMEOUT-1 without gnt (REQ) or rvalid (WAIT), go to DONE with lsu_fault=1. mem_req drops, and later responses are ignored.
- Undefined: no counter; REQ and WAIT wait forever; lsu_fault is tied 0.

Decomposition:
- risc_pkg gains op_enum_lsu (LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW).
- risc_pkg also gains the lsu_state_t enum.
- Sub-module lsu_align: purely combinational. Store be/wdata generation, load lane select and extension, misalignment detect. The FSM and registers stay in lsu.

Test Plan:
- SW addr=0x100 d=0xDEADBEEF, gnt in the first REQ cycle -> mem_addr=0x100, be=4'b1111, we=1. lsu_done exactly 2 cycles after acceptance; lsu_rdata unchanged.
- LB addr=0x103, mem_rdata=0x80FF1234 -> lsu_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr=0x202 d=0x0000ABCD -> mem_addr=0x200, be=4'b1100, wdata=0xABCDABCD.
- LW addr=0x102 -> no mem_req. lsu_done and lsu_misalign=1 on the next cycle.
- LH addr=0x10, gnt held low 3 cycles, then rvalid 2 cycles after gnt with rdata=0x00007FFF -> lsu_busy high throughout, lsu_rdata=0x00007FFF, done on the cycle after rvalid.
- rst_n=0 during WAIT, then rvalid arrives -> state IDLE, all outputs 0, no lsu_done. With LSU_TIMEOUT_EN, gnt never arrives -> lsu_fault=1 with lsu_done after TIMEOUT cycles in REQ.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared core types: LSU operation encoding and LSU FSM states.
package risc_pkg;

  typedef enum logic [3:0] {
    LSU_NONE,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } op_enum_lsu;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  function automatic logic lsu_is_store(op_enum_lsu op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane logic: store byte enables/replication,
// misalignment detect and load lane select with sign/zero extension.
module lsu_align
  import risc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_enum_lsu        st_op,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN/8-1:0] st_be,
  output logic [XLEN-1:0]   st_wdata,
  output logic              st_misalign,
  input  op_enum_lsu        ld_op,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be       = 4'b1111;
    st_wdata    = st_data;
    st_misalign = 1'b0;
    case (st_op)
      LSU_SB: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      LSU_SH: begin
        st_be       = 4'b0011 << {st_off[1], 1'b0};
        st_wdata    = {2{st_data[15:0]}};
        st_misalign = st_off[0];
      end
      LSU_LH, LSU_LHU: st_misalign = st_off[0];
      LSU_LW, LSU_SW:  st_misalign = |st_off;
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_op)
      LSU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LSU_LBU: ld_data = {24'd0, ld_byte};
      LSU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      LSU_LHU: ld_data = {16'd0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one req/gnt/rvalid transaction per instruction.
// Defining LSU_TIMEOUT_EN adds a watchdog that aborts a stalled REQ/WAIT with lsu_fault.
module lsu
  import risc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  input  op_enum_lsu        lsu_op,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_misalign,
  output logic              lsu_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN/8-1:0] mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  op_enum_lsu        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              busy_c;
  logic              expired;

  logic [XLEN/8-1:0] st_be;
  logic [XLEN-1:0]   st_wdata;
  logic              st_misalign;
  logic [XLEN-1:0]   ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_op       (lsu_op),
    .st_off      (lsu_addr[1:0]),
    .st_data     (lsu_wdata),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .st_misalign (st_misalign),
    .ld_op       (op_q),
    .ld_off      (off_q),
    .ld_raw      (mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    op_d        = op_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    misalign_d  = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid && (lsu_op != LSU_NONE)) begin
          busy_c = 1'b1;
          if (st_misalign) begin
            misalign_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            mem_addr_d  = {lsu_addr[XLEN-1:2], 2'b00};
            mem_we_d    = lsu_is_store(lsu_op);
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
            op_d        = lsu_op;
            off_d       = lsu_addr[1:0];
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        busy_c = 1'b1;
        if (mem_gnt) begin
          state_d = lsu_is_store(op_q) ? S_DONE : S_WAIT;
        end else if (expired) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        busy_c = 1'b1;
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = S_DONE;
        end else if (expired) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      op_q        <= LSU_NONE;
      off_q       <= 2'b00;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // The counter restarts on every state change, so it measures time in the current REQ/WAIT.
  always_comb begin
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (expired && (((state_q == S_REQ) && !mem_gnt) || ((state_q == S_WAIT) && !mem_rvalid))) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign lsu_fault = (state_q == S_DONE) && fault_q;
`else
  assign expired   = 1'b0;
  assign lsu_fault = 1'b0;
`endif

  assign lsu_busy     = rst_n && busy_c;
  assign lsu_done     = (state_q == S_DONE);
  assign lsu_misalign = (state_q == S_DONE) && misalign_q;
  assign lsu_rdata    = rdata_q;
  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
